ram_burst_ctrl: RTL and testbench

Burst initiator for the team's synchronous single-port RAM (`single_port_ram`: clk, we, addr, din, dout). It accepts one burst command at a time (write or read, start address, length) and sequences the RAM port. Write data and read data move over valid/ready streams. It replaces hand-driven address/we sequences as the standard way logic talks to that RAM.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/single_port_ram.sv | 31 +++
 rtl/ram_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the single-port RAM burst controller: FSM state
// encoding and the default address/data widths used by the controller and
// by logic that instantiates it next to single_port_ram.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/single_port_ram.sv
// single_port_ram
// Synchronous single-port RAM. A write stores din at addr on the rising edge
// when we=1. dout is registered: it shows the contents of the address that
// was presented on the previous edge (read-before-write on a write cycle).
// Ports:
//   clk  in   clock
//   we   in   write enable
//   addr in   ADDR_W address
//   din  in   DATA_W write data
//   dout out  DATA_W registered read data
module single_port_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Burst initiator for single_port_ram. Accepts one write or read burst command
// at a time (start address, beats minus one) and sequences the RAM port.
// Write beats arrive on a valid/ready stream and go to the RAM in the same
// cycle; read beats take three cycles each (issue address, wait for the
// registered RAM output, present it on the read stream until taken).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write, cmd_addr,
//   cmd_len                    burst type, start address, beats minus one
//   wr_valid/wr_ready/wr_data  write beat stream into the controller
//   rd_valid/rd_ready/rd_data  read beat stream out of the controller
//   busy                       burst in progress
//   done                       one-cycle pulse in IDLE after the last beat
//   ram_we/ram_addr/ram_din    drive the RAM port
//   ram_dout                   registered RAM read data
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] w_cur_addr_nxt;
  logic [ADDR_W-1:0] r_beats_left;
  logic [ADDR_W-1:0] w_beats_left_nxt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_rd_load;
  logic              w_last;

  // beats_left counts the beats remaining after the current one, so zero
  // marks the final beat and an all-ones length covers the whole array.
  assign w_last = (r_beats_left == '0);

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_beats_left_nxt = r_beats_left;
    w_done_nxt       = 1'b0;
    w_rd_load        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cur_addr_nxt   = cmd_addr;
          w_beats_left_nxt = cmd_len;
          w_state_nxt      = cmd_write ? ST_WR : ST_RD_ISSUE;
        end
      end
      ST_WR: begin
        if (wr_valid) begin
          // Address wraps naturally at the top of the array.
          w_cur_addr_nxt   = r_cur_addr + 1'b1;
          w_beats_left_nxt = r_beats_left - 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // RAM output now reflects the address issued last cycle.
        w_rd_load   = 1'b1;
        w_state_nxt = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (rd_ready) begin
          w_cur_addr_nxt   = r_cur_addr + 1'b1;
          w_beats_left_nxt = r_beats_left - 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RD_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_done       <= w_done_nxt;
      if (w_rd_load) begin
        r_rd_data <= ram_dout;
      end
    end
  end

  // Every control output is masked by rst so nothing reaches the RAM or the
  // streams while reset is held, regardless of the registered state.
  assign cmd_ready = ~rst & (r_state == ST_IDLE);
  assign wr_ready  = ~rst & (r_state == ST_WR);
  assign rd_valid  = ~rst & (r_state == ST_RD_OUT);
  assign busy      = ~rst & (r_state != ST_IDLE);
  assign done      = ~rst & r_done;
  assign ram_we    = ~rst & (r_state == ST_WR) & wr_valid;
  assign ram_addr  = rst ? '0 : r_cur_addr;
  assign ram_din   = wr_data;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl driving an external single_port_ram.
// The stimulus side keeps a behavioural image of the RAM (an array indexed
// modulo the depth) and queues the expected RAM writes and read beats; a
// monitor on the falling edge pops and compares whenever the DUT writes the
// RAM or hands over a read beat.
module tb_ram_burst_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  single_port_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  logic [AW+DW-1:0] wq [$];     // expected RAM writes {addr, data}
  logic [DW-1:0]    rq [$];     // expected read beats
  logic [DW-1:0]    mem_model [DEPTH];
  logic [DW-1:0]    wdata [$];  // data for the next write burst

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [AW+DW-1:0] m_exp_w;
  logic [DW-1:0]    m_exp_r;
  logic             m_hold = 1'b0;
  logic [DW-1:0]    m_hold_data;

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      if (wq.size() == 0) fail_now("ram_we_unexpected");
      else begin
        m_exp_w = wq.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(m_exp_w[AW+DW-1:DW]));
        chk("wr_data", 32'(ram_din),  32'(m_exp_w[DW-1:0]));
      end
    end
    if (done) done_cnt++;
    if (!rst && rd_valid) begin
      if (m_hold) chk("rd_data_held", 32'(rd_data), 32'(m_hold_data));
      if (rd_ready) begin
        m_hold = 1'b0;
        if (rq.size() == 0) fail_now("rd_beat_unexpected");
        else begin
          m_exp_r = rq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(m_exp_r));
        end
      end else begin
        m_hold      = 1'b1;
        m_hold_data = rd_data;
      end
    end else begin
      m_hold = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    if (!got) fail_now("cmd_accept_timeout");
  endtask

  // Called right after the edge that consumed the final beat.
  task automatic end_check();
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  // gap_mode: 0 none, 1 one idle cycle before beat 1, 2 random idle cycles
  task automatic wr_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input int gap_mode, input bit cmd_busy);
    int acc, prev, c, idx;
    logic [DW-1:0] d;
    send_cmd(1'b1, a, l, acc);
    prev = acc;
    for (int i = 0; i <= int'(l); i++) begin
      if ((gap_mode == 1 && i == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("gap_no_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
      end
      idx = (int'(a) + i) % DEPTH;
      d   = (wdata.size() != 0) ? wdata.pop_front() : DW'($urandom);
      wr_valid = 1'b1;
      wr_data  = d;
      wq.push_back({AW'(idx), d});
      mem_model[idx] = d;
      if (cmd_busy) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
      end
      c = -1;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (wr_ready) begin c = cyc; break; end
        @(posedge clk); #1;
      end
      if (c < 0) fail_now("wr_ready_timeout");
      else begin
        if (cmd_busy) chk("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
        if (gap_mode == 0) chk("wr_beat_cycle", 32'(c), 32'(prev + 1));
        prev = c;
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
    end
    wr_valid = 1'b0;
    end_check();
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input int stall_beat, input int stall_len, input bit rnd);
    int acc, prev, beat, scnt, n;
    logic [AW-1:0] saddr;
    n = int'(l) + 1;
    beat = 0; scnt = 0; saddr = '0;
    for (int i = 0; i < n; i++) rq.push_back(mem_model[(int'(a) + i) % DEPTH]);
    send_cmd(1'b0, a, l, acc);
    prev = acc;
    for (int k = 0; k < 400 && beat < n; k++) begin
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      else     rd_ready = !(beat == stall_beat && scnt < stall_len);
      @(negedge clk);
      if (rd_valid && !rd_ready && beat == stall_beat) begin
        if (scnt == 0) saddr = ram_addr;
        else chk("stall_addr_hold", 32'(ram_addr), 32'(saddr));
        scnt++;
      end
      if (rd_valid && rd_ready) begin
        if (!rnd && stall_beat < 0) chk("rd_beat_cycle", 32'(cyc), 32'(prev + 3));
        prev = cyc;
        beat++;
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    if (beat < n) begin
      fail_now("rd_burst_timeout");
      rq.delete();
    end else begin
      if (stall_beat >= 0) chk("stall_cycles", 32'(scnt), 32'(stall_len));
      end_check();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int we0, dc0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_rd_data", 32'(rd_data), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    // Basic write then read, timing checked
    wdata = '{8'h81, 8'hEA, 8'hFF};
    wr_burst(4'h0, 4'd2, 0, 1'b0);
    rd_burst(4'h0, 4'd2, -1, 0, 1'b0);

    // Wrap across the top address
    wdata = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_burst(4'hE, 4'd3, 0, 1'b0);
    rd_burst(4'hE, 4'd3, -1, 0, 1'b0);

    // Read backpressure on the second beat
    rd_burst(4'h0, 4'd2, 1, 5, 1'b0);

    // Write with a one-cycle gap
    we0 = we_cnt;
    wdata = '{8'h5A, 8'hA5};
    wr_burst(4'h6, 4'd1, 1, 1'b0);
    chk("gap_we_pulses", 32'(we_cnt - we0), 32'd2);

    // Full depth with commands offered while busy
    for (int i = 0; i < DEPTH; i++) wdata.push_back(DW'($urandom));
    we0 = we_cnt;
    wr_burst(4'h0, 4'hF, 0, 1'b1);
    chk("full_we_pulses", 32'(we_cnt - we0), 32'd16);
    rd_burst(4'h0, 4'hF, -1, 0, 1'b0);

    // Reset after the first beat of a 4-beat write at 8
    begin
      int acc;
      logic [DW-1:0] d0;
      dc0 = done_cnt;
      d0 = 8'hC3;
      send_cmd(1'b1, 4'h8, 4'd3, acc);
      wr_valid = 1'b1; wr_data = d0;
      wq.push_back({4'h8, d0});
      mem_model[8] = d0;
      @(negedge clk);
      chk("abort_wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; wr_data = 8'h3C;
      repeat (2) begin
        @(negedge clk);
        chk("abort_rst_we", 32'(ram_we), 32'd0);
        chk("abort_rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("abort_rst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
      end
      rst = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd_data", 32'(rd_data), 32'd0);
      @(posedge clk); #1;
      repeat (5) begin @(posedge clk); #1; end
      chk("abort_no_done", 32'(done_cnt), 32'(dc0));
      rd_burst(4'h8, 4'd3, -1, 0, 1'b0);
    end

    // Random bursts with random gaps and backpressure
    for (int t = 0; t < 20; t++) begin
      logic [AW-1:0] a, l;
      a = AW'($urandom);
      l = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) wr_burst(a, l, 2, 1'b0);
      else                           rd_burst(a, l, -1, 0, 1'b1);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
